traffic_phase_scheduler: RTL and testbench



---
 rtl/traffic_pkg.sv | 44 ++++
 rtl/phase_timer.sv | 30 +++
 rtl/traffic_phase_scheduler.sv | 173 +++++++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared phase encoding, lamp patterns and lamp decode for the intersection phase scheduler.
package traffic_pkg;

    localparam logic [2:0] PH_EW_G  = 3'd0;
    localparam logic [2:0] PH_EW_L  = 3'd1;
    localparam logic [2:0] PH_EW_Y  = 3'd2;
    localparam logic [2:0] PH_EW_AR = 3'd3;
    localparam logic [2:0] PH_SN_G  = 3'd4;
    localparam logic [2:0] PH_SN_L  = 3'd5;
    localparam logic [2:0] PH_SN_Y  = 3'd6;
    localparam logic [2:0] PH_SN_AR = 3'd7;

    localparam logic [3:0] LAMP_RED    = 4'b1000;
    localparam logic [3:0] LAMP_GREEN  = 4'b0100;
    localparam logic [3:0] LAMP_YELLOW = 4'b0010;
    localparam logic [3:0] LAMP_LEFT   = 4'b1001;

    typedef enum logic [2:0] {
        EW_G  = PH_EW_G,
        EW_L  = PH_EW_L,
        EW_Y  = PH_EW_Y,
        EW_AR = PH_EW_AR,
        SN_G  = PH_SN_G,
        SN_L  = PH_SN_L,
        SN_Y  = PH_SN_Y,
        SN_AR = PH_SN_AR
    } phase_e;

    // Bit 2 of the phase code selects the road that owns the phase; bits 1:0 select G/L/Y/AR.
    function automatic logic [3:0] lamp_for(input logic road_sn, input logic [2:0] ph);
        logic [3:0] lamp;
        lamp = LAMP_RED;
        if (ph[2] == road_sn) begin
            case (ph[1:0])
                2'd0:    lamp = LAMP_GREEN;
                2'd1:    lamp = LAMP_LEFT;
                2'd2:    lamp = LAMP_YELLOW;
                default: lamp = LAMP_RED;
            endcase
        end
        return lamp;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase dwell counter: counts elapsed cycles, clears on phase change, can freeze,
// and flags the terminal count against the current phase limit.
module phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_freeze,
    input  logic [CNT_W-1:0] i_limit,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_done
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (!i_freeze) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_done = (r_cnt == i_limit);

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Two-road intersection phase scheduler with demand-driven left turns and green truncation.
// Optional emergency preemption is built when EMERGENCY_PREEMPT_EN is defined.
//
// state | meaning
// EW_G  | EW straight green
// EW_L  | EW left-turn arrow (only when a left vehicle was sensed)
// EW_Y  | EW yellow
// EW_AR | all-red clearance after EW
// SN_G  | SN straight green
// SN_L  | SN left-turn arrow
// SN_Y  | SN yellow
// SN_AR | all-red clearance after SN
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int T_GREEN     = 20,
    parameter int T_GREEN_MIN = 6,
    parameter int T_LEFT      = 8,
    parameter int T_YELLOW    = 3,
    parameter int T_ALLRED    = 2
) (
    input  logic             clk,
    input  logic             reset,
`ifdef EMERGENCY_PREEMPT_EN
    input  logic             emg_req,
    input  logic             emg_dir,
`endif
    input  logic             req_ew,
    input  logic             req_sn,
    input  logic             left_ew,
    input  logic             left_sn,
    output logic [3:0]       light_ew_rgyl,
    output logic [3:0]       light_sn_rgyl,
    output logic [2:0]       status,
    output logic [CNT_W-1:0] phase_cnt,
    output logic             ack_ew,
    output logic             ack_sn
);

    localparam logic [CNT_W-1:0] LIM_GREEN  = CNT_W'(T_GREEN - 1);
    localparam logic [CNT_W-1:0] LIM_LEFT   = CNT_W'(T_LEFT - 1);
    localparam logic [CNT_W-1:0] LIM_YELLOW = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] LIM_ALLRED = CNT_W'(T_ALLRED - 1);
    localparam logic [CNT_W-1:0] MIN_M1     = CNT_W'(T_GREEN_MIN - 1);

    phase_e           r_phase;
    phase_e           w_next;
    logic [3:0]       r_light_ew;
    logic [3:0]       r_light_sn;
    logic             r_ack_ew;
    logic             r_ack_sn;
    logic             r_req_pend_ew;
    logic             r_req_pend_sn;
    logic             r_left_pend_ew;
    logic             r_left_pend_sn;

    logic [CNT_W-1:0] w_cnt;
    logic [CNT_W-1:0] w_limit;
    logic             w_done;
    logic             w_clear;
    logic             w_hold;
    logic             w_preempt;
    logic             w_trunc_ew;
    logic             w_trunc_sn;
    logic             w_take_left_ew;
    logic             w_take_left_sn;

    // A request sampled on this edge counts, so a demand can end the opposing green immediately.
    assign w_trunc_ew     = (r_req_pend_sn | req_sn) && (w_cnt >= MIN_M1);
    assign w_trunc_sn     = (r_req_pend_ew | req_ew) && (w_cnt >= MIN_M1);
    assign w_take_left_ew = r_left_pend_ew | left_ew;
    assign w_take_left_sn = r_left_pend_sn | left_sn;

    always_comb begin
        w_limit = LIM_ALLRED;
        case (r_phase)
            EW_G, SN_G: w_limit = LIM_GREEN;
            EW_L, SN_L: w_limit = LIM_LEFT;
            EW_Y, SN_Y: w_limit = LIM_YELLOW;
            default:    w_limit = LIM_ALLRED;
        endcase
    end

    always_comb begin
        w_next    = r_phase;
        w_hold    = 1'b0;
        w_preempt = 1'b0;
        case (r_phase)
            EW_G:    if (w_done || w_trunc_ew) w_next = w_take_left_ew ? EW_L : EW_Y;
            EW_L:    if (w_done) w_next = EW_Y;
            EW_Y:    if (w_done) w_next = EW_AR;
            EW_AR:   if (w_done) w_next = SN_G;
            SN_G:    if (w_done || w_trunc_sn) w_next = w_take_left_sn ? SN_L : SN_Y;
            SN_L:    if (w_done) w_next = SN_Y;
            SN_Y:    if (w_done) w_next = SN_AR;
            SN_AR:   if (w_done) w_next = EW_G;
            default: w_next = EW_G;
        endcase
`ifdef EMERGENCY_PREEMPT_EN
        if (emg_req) begin
            if (r_phase == (emg_dir ? SN_G : EW_G)) begin
                w_hold = 1'b1;
                w_next = r_phase;
            end else if (!emg_dir && (r_phase == SN_G || r_phase == SN_L)) begin
                w_preempt = 1'b1;
                w_next    = SN_Y;
            end else if (emg_dir && (r_phase == EW_G || r_phase == EW_L)) begin
                w_preempt = 1'b1;
                w_next    = EW_Y;
            end
        end
`endif
    end

    // A held green parks the counter at zero so release starts a full green.
    assign w_clear = (w_next != r_phase) || (w_hold && (w_cnt != '0));

    phase_timer #(
        .CNT_W(CNT_W)
    ) u_phase_timer (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_clear),
        .i_freeze (w_hold),
        .i_limit  (w_limit),
        .o_cnt    (w_cnt),
        .o_done   (w_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase        <= EW_G;
            r_light_ew     <= LAMP_GREEN;
            r_light_sn     <= LAMP_RED;
            r_ack_ew       <= 1'b0;
            r_ack_sn       <= 1'b0;
            r_req_pend_ew  <= 1'b0;
            r_req_pend_sn  <= 1'b0;
            r_left_pend_ew <= 1'b0;
            r_left_pend_sn <= 1'b0;
        end else begin
            r_phase    <= w_next;
            r_light_ew <= lamp_for(1'b0, w_next);
            r_light_sn <= lamp_for(1'b1, w_next);

            r_ack_ew      <= (w_next == EW_G) && (r_req_pend_ew || req_ew);
            r_ack_sn      <= (w_next == SN_G) && (r_req_pend_sn || req_sn);
            r_req_pend_ew <= (w_next != EW_G) && (r_req_pend_ew || req_ew);
            r_req_pend_sn <= (w_next != SN_G) && (r_req_pend_sn || req_sn);

            if (r_phase == EW_G) begin
                r_left_pend_ew <= (w_next == EW_Y && !w_preempt) ? 1'b0 : w_take_left_ew;
            end else if (r_phase == EW_L && w_next != EW_L) begin
                r_left_pend_ew <= 1'b0;
            end

            if (r_phase == SN_G) begin
                r_left_pend_sn <= (w_next == SN_Y && !w_preempt) ? 1'b0 : w_take_left_sn;
            end else if (r_phase == SN_L && w_next != SN_L) begin
                r_left_pend_sn <= 1'b0;
            end
        end
    end

    assign status        = r_phase;
    assign phase_cnt     = w_cnt;
    assign light_ew_rgyl = r_light_ew;
    assign light_sn_rgyl = r_light_sn;
    assign ack_ew        = r_ack_ew;
    assign ack_sn        = r_ack_sn;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler: directed phase-dwell scenarios plus randomized demand,
// checked against a phase-table reference model. Emergency scenario built with EMERGENCY_PREEMPT_EN.
module tb_traffic_phase_scheduler;

    localparam int CNT_W       = 8;
    localparam int T_GREEN     = 20;
    localparam int T_GREEN_MIN = 6;
    localparam int T_LEFT      = 8;
    localparam int T_YELLOW    = 3;
    localparam int T_ALLRED    = 2;

    logic             clk     = 1'b0;
    logic             reset   = 1'b1;
    logic             req_ew  = 1'b0;
    logic             req_sn  = 1'b0;
    logic             left_ew = 1'b0;
    logic             left_sn = 1'b0;
    logic             emg_req = 1'b0;
    logic             emg_dir = 1'b0;
    logic [3:0]       light_ew_rgyl;
    logic [3:0]       light_sn_rgyl;
    logic [2:0]       status;
    logic [CNT_W-1:0] phase_cnt;
    logic             ack_ew;
    logic             ack_sn;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: phase index = road*4 + kind (kind 0=G,1=L,2=Y,3=AR).
    int m_ph  = 0;
    int m_cnt = 0;
    bit m_rp[2];
    bit m_lp[2];
    bit m_ack[2];

    int exp_full[8] = '{20, 8, 3, 2, 20, 8, 3, 2};
    int exp_skip[6] = '{20, 3, 2, 20, 3, 2};

    always #5 clk = ~clk;

    traffic_phase_scheduler #(
        .CNT_W       (CNT_W),
        .T_GREEN     (T_GREEN),
        .T_GREEN_MIN (T_GREEN_MIN),
        .T_LEFT      (T_LEFT),
        .T_YELLOW    (T_YELLOW),
        .T_ALLRED    (T_ALLRED)
    ) dut (
        .clk           (clk),
        .reset         (reset),
`ifdef EMERGENCY_PREEMPT_EN
        .emg_req       (emg_req),
        .emg_dir       (emg_dir),
`endif
        .req_ew        (req_ew),
        .req_sn        (req_sn),
        .left_ew       (left_ew),
        .left_sn       (left_sn),
        .light_ew_rgyl (light_ew_rgyl),
        .light_sn_rgyl (light_sn_rgyl),
        .status        (status),
        .phase_cnt     (phase_cnt),
        .ack_ew        (ack_ew),
        .ack_sn        (ack_sn)
    );

    function automatic int dur(input int ph);
        case (ph % 4)
            0:       return T_GREEN;
            1:       return T_LEFT;
            2:       return T_YELLOW;
            default: return T_ALLRED;
        endcase
    endfunction

    function automatic logic [3:0] lamp(input int road, input int ph);
        if (ph / 4 != road || ph % 4 == 3) return 4'b1000;
        case (ph % 4)
            0:       return 4'b0100;
            1:       return 4'b1001;
            default: return 4'b0010;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_advance();
        bit req[2];
        bit lft[2];
        int r, k, o, nph, ncnt, ed;
        bit leave, hold, pre;
        req[0] = req_ew;  req[1] = req_sn;
        lft[0] = left_ew; lft[1] = left_sn;
        ed = int'(emg_dir);
        if (reset) begin
            m_ph = 0; m_cnt = 0;
            for (int x = 0; x < 2; x++) begin
                m_rp[x] = 0; m_lp[x] = 0; m_ack[x] = 0;
            end
        end else begin
            r = m_ph / 4; k = m_ph % 4; o = 1 - r;
            leave = (m_cnt == dur(m_ph) - 1) ||
                    (k == 0 && (m_rp[o] || req[o]) && m_cnt >= T_GREEN_MIN - 1);
            nph = m_ph;
            if (leave)
                nph = (k == 0) ? ((m_lp[r] || lft[r]) ? m_ph + 1 : m_ph + 2) : (m_ph + 1) % 8;
            hold = 0; pre = 0;
            if (emg_req) begin
                if (m_ph == 4 * ed) begin
                    hold = 1; nph = m_ph;
                end else if (r != ed && k <= 1) begin
                    pre = 1; nph = 4 * r + 2;
                end
            end
            ncnt = (nph != m_ph || hold) ? 0 : m_cnt + 1;
            if (k == 0)
                m_lp[r] = (nph == 4 * r + 2 && !pre) ? 1'b0 : (m_lp[r] | lft[r]);
            else if (k == 1 && nph != m_ph)
                m_lp[r] = 0;
            for (int x = 0; x < 2; x++) begin
                if (nph == 4 * x) begin
                    m_ack[x] = m_rp[x] | req[x];
                    m_rp[x]  = 0;
                end else begin
                    m_ack[x] = 0;
                    m_rp[x]  = m_rp[x] | req[x];
                end
            end
            m_ph = nph; m_cnt = ncnt;
        end
    endtask

    task automatic step();
        model_advance();
        @(posedge clk);
        #1;
        n_vec++;
        chk("status", 32'(status), 32'(m_ph));
        chk("phase_cnt", 32'(phase_cnt), 32'(m_cnt));
        chk("lamp_ew", 32'(light_ew_rgyl), 32'(lamp(0, m_ph)));
        chk("lamp_sn", 32'(light_sn_rgyl), 32'(lamp(1, m_ph)));
        chk("ack_ew", 32'(ack_ew), 32'(m_ack[0]));
        chk("ack_sn", 32'(ack_sn), 32'(m_ack[1]));
    endtask

    // Steps until status changes; optionally pulses one request when phase_cnt == pulse_at.
    task automatic dwell(input int pulse_at, input bit on_sn, output int n, output bit ack_after);
        logic [2:0] ph;
        bit pulsed;
        ph = status;
        n = 0;
        ack_after = 0;
        do begin
            pulsed = (int'(phase_cnt) == pulse_at);
            if (pulsed) begin
                if (on_sn) req_sn = 1'b1;
                else       req_ew = 1'b1;
            end
            step();
            n++;
            if (pulsed) ack_after = on_sn ? ack_sn : ack_ew;
            req_ew = 1'b0;
            req_sn = 1'b0;
        end while (status == ph && n < 200);
        if (n >= 200) begin
            n_err++;
            $error("FAIL dwell_bound: observed %0d cycles in phase %0d expected fewer than 200", n, ph);
        end
    endtask

    initial begin
        int n, total;
        bit a;

        reset = 1'b1;
        step();
        step();
        chk("rst_status", 32'(status), 32'd0);
        chk("rst_cnt", 32'(phase_cnt), 32'd0);
        chk("rst_lamp_ew", 32'(light_ew_rgyl), 32'h4);
        chk("rst_lamp_sn", 32'(light_sn_rgyl), 32'h8);
        reset = 1'b0;

        // Full cycle with left turns demanded.
        left_ew = 1'b1; left_sn = 1'b1;
        total = 0;
        for (int i = 0; i < 8; i++) begin
            dwell(-1, 1'b0, n, a);
            chk("full_dwell", 32'(n), 32'(exp_full[i]));
            total += n;
        end
        chk("full_total", 32'(total), 32'd66);

        // Left phases skipped.
        left_ew = 1'b0; left_sn = 1'b0;
        total = 0;
        for (int i = 0; i < 6; i++) begin
            dwell(-1, 1'b0, n, a);
            chk("skip_dwell", 32'(n), 32'(exp_skip[i]));
            total += n;
        end
        chk("skip_total", 32'(total), 32'd50);

        // Truncation of SN_G by an EW request.
        for (int i = 0; i < 3; i++) dwell(-1, 1'b0, n, a);
        dwell(10, 1'b0, n, a);
        chk("trunc_at10", 32'(n), 32'd11);
        dwell(-1, 1'b0, n, a);
        dwell(-1, 1'b0, n, a);
        chk("ack_first_ewg_status", 32'(status), 32'd0);
        chk("ack_first_ewg", 32'(ack_ew), 32'd1);
        for (int i = 0; i < 3; i++) dwell(-1, 1'b0, n, a);
        dwell(2, 1'b0, n, a);
        chk("trunc_at2", 32'(n), 32'd6);
        dwell(-1, 1'b0, n, a);
        dwell(-1, 1'b0, n, a);

        // Own-green request acknowledged immediately, green not shortened.
        dwell(5, 1'b0, n, a);
        chk("own_ack", 32'(a), 32'd1);
        chk("own_dwell", 32'(n), 32'd20);

        // Reset in SN_Y with an EW request pending.
        for (int i = 0; i < 3; i++) dwell(-1, 1'b0, n, a);
        chk("at_sn_y", 32'(status), 32'd6);
        req_ew = 1'b1;
        step();
        req_ew = 1'b0;
        reset = 1'b1;
        step();
        chk("midrst_status", 32'(status), 32'd0);
        chk("midrst_cnt", 32'(phase_cnt), 32'd0);
        chk("midrst_lamp_ew", 32'(light_ew_rgyl), 32'h4);
        chk("midrst_lamp_sn", 32'(light_sn_rgyl), 32'h8);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("midrst_no_ack", 32'(ack_ew), 32'd0);
        end

        // Randomized demand against the model.
        for (int i = 0; i < 800; i++) begin
            req_ew  = ($urandom_range(0, 15) == 0);
            req_sn  = ($urandom_range(0, 15) == 0);
            left_ew = ($urandom_range(0, 7) == 0);
            left_sn = ($urandom_range(0, 7) == 0);
            reset   = ($urandom_range(0, 299) == 0);
            step();
        end
        req_ew = 1'b0; req_sn = 1'b0; left_ew = 1'b0; left_sn = 1'b0; reset = 1'b0;

`ifdef EMERGENCY_PREEMPT_EN
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("emg_start_cnt", 32'(phase_cnt), 32'd4);
        emg_req = 1'b1; emg_dir = 1'b1;
        step();
        chk("emg_cut_to_y", 32'(status), 32'd2);
        dwell(-1, 1'b0, n, a);
        chk("emg_y_dwell", 32'(n), 32'd3);
        dwell(-1, 1'b0, n, a);
        chk("emg_ar_dwell", 32'(n), 32'd2);
        for (int i = 0; i < 30; i++) begin
            step();
            chk("emg_hold_status", 32'(status), 32'd4);
            chk("emg_hold_cnt", 32'(phase_cnt), 32'd0);
        end
        emg_req = 1'b0;
        dwell(-1, 1'b0, n, a);
        chk("emg_release_dwell", 32'(n), 32'd20);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
